// File: rtl/sram_fifo_ctrl_if.sv
// Valid/ready write and read streams of the SRAM-backed FIFO controller,
// plus the occupancy count.
interface sram_fifo_ctrl_if #(
   parameter int unsigned BITWIDTH = 32,
   parameter int unsigned DEPTH    = 8
) ();
   logic                in_valid;
   logic                in_ready;
   logic [BITWIDTH-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [BITWIDTH-1:0] out_data;
   logic [DEPTH+1:0]    count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving one dual-port SRAM (1-cycle registered read); a 2-entry
// output buffer hides the read latency so the output stream runs at full rate.
module sram_fifo_ctrl #(
   parameter int unsigned BITWIDTH = 32,
   parameter int unsigned DEPTH    = 8
) (
   input  logic                CLK,
   input  logic                RST,
   sram_fifo_ctrl_if.slave     fifo,
   output logic [BITWIDTH-1:0] sram_D,
   output logic                sram_WEB,
   output logic [BITWIDTH-1:0] sram_BWEB,
   output logic [DEPTH-1:0]    sram_AA,
   output logic                sram_REB,
   output logic [DEPTH-1:0]    sram_AB,
   input  logic [BITWIDTH-1:0] sram_Q
);

   localparam logic [DEPTH:0] SramFull = {1'b1, {DEPTH{1'b0}}};

   logic [DEPTH-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH:0]      sram_cnt_q, sram_cnt_d;
   logic                inflight_q;
   logic [BITWIDTH-1:0] buf_q [2];
   logic                head_q, head_d;
   logic [1:0]          buf_cnt_q, buf_cnt_d;
   logic [DEPTH+1:0]    count_q, count_d;
   logic                accept, pop, issue;
   logic [2:0]          occ_next;

   assign fifo.in_ready  = !RST && (sram_cnt_q != SramFull);
   assign fifo.out_valid = (buf_cnt_q != 2'd0);
   assign fifo.out_data  = buf_q[head_q];
   assign fifo.count     = count_q;

   assign accept = fifo.in_valid && fifo.in_ready;
   assign pop    = fifo.out_valid && fifo.out_ready;

   // Buffer slots that will be claimed after this edge if nothing new is issued.
   assign occ_next = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue    = !RST && (sram_cnt_q != '0) && (occ_next < 3'd2);

   assign sram_D    = fifo.in_data;
   assign sram_WEB  = accept;
   assign sram_BWEB = '1;
   assign sram_AA   = wr_ptr_q;
   assign sram_REB  = issue;
   assign sram_AB   = rd_ptr_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      sram_cnt_d = sram_cnt_q;
      count_d    = count_q;
      head_d     = head_q;
      buf_cnt_d  = buf_cnt_q;

      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (pop)    head_d   = ~head_q;

      case ({accept, issue})
         2'b10:   sram_cnt_d = sram_cnt_q + 1'b1;
         2'b01:   sram_cnt_d = sram_cnt_q - 1'b1;
         default: sram_cnt_d = sram_cnt_q;
      endcase

      case ({accept, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      case ({inflight_q, pop})
         2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
         2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
         default: buf_cnt_d = buf_cnt_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sram_cnt_q <= '0;
         inflight_q <= 1'b0;
         head_q     <= 1'b0;
         buf_cnt_q  <= '0;
         count_q    <= '0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sram_cnt_q <= sram_cnt_d;
         inflight_q <= issue;
         head_q     <= head_d;
         buf_cnt_q  <= buf_cnt_d;
         count_q    <= count_d;
         // A capture never meets a full buffer, so the tail slot is head or the other one.
         if (inflight_q) buf_q[head_q ^ buf_cnt_q[0]] <= sram_Q;
      end
   end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural dual-port SRAM and a
// queue scoreboard for the streaming phases.
module tb_sram_fifo_ctrl;

   localparam int unsigned BW = 32;
   localparam int unsigned DP = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [BW-1:0] sram_D, sram_BWEB, sram_Q;
   logic          sram_WEB, sram_REB;
   logic [DP-1:0] sram_AA, sram_AB;
   logic [BW-1:0] mem [2**DP];

   int            checks   = 0;
   int            failures = 0;
   logic [BW-1:0] q [$];
   logic [BW-1:0] next_word = 32'h0;
   int            first_out;
   int            acc;

   sram_fifo_ctrl_if #(.BITWIDTH(BW), .DEPTH(DP)) fifo_if ();

   sram_fifo_ctrl #(.BITWIDTH(BW), .DEPTH(DP)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .fifo      (fifo_if),
      .sram_D    (sram_D),
      .sram_WEB  (sram_WEB),
      .sram_BWEB (sram_BWEB),
      .sram_AA   (sram_AA),
      .sram_REB  (sram_REB),
      .sram_AB   (sram_AB),
      .sram_Q    (sram_Q)
   );

   always #5 CLK = ~CLK;

   // Registered-read SRAM; Q holds while REB is low.
   always @(posedge CLK) begin
      if (sram_WEB) mem[sram_AA] <= sram_D;
      if (sram_REB) sram_Q <= mem[sram_AB];
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pushes nwords fresh words and drains everything queued; returns the loop cycle of the
   // first pop. With nogap set, out_valid must stay high from the first pop to the end.
   task automatic run_traffic(input int nwords, input int iv_pct, input int or_pct,
                              input bit nogap, output int first_cyc);
      int            sent    = 0;
      int            got     = 0;
      int            target  = q.size() + nwords;
      int            cyc     = 0;
      bit            started = 1'b0;
      bit            stalled = 1'b0;
      logic [BW-1:0] held    = '0;
      logic [BW-1:0] exp_w;
      first_cyc = -1;
      while (got < target && cyc < nwords * 10 + 600) begin
         fifo_if.in_valid  = (sent < nwords) && ($urandom_range(99) < iv_pct);
         fifo_if.in_data   = next_word;
         fifo_if.out_ready = ($urandom_range(99) < or_pct);
         #1;
         if (stalled) begin
            check("stall_valid", 64'(fifo_if.out_valid), 64'd1);
            check("stall_data", 64'(fifo_if.out_data), 64'(held));
         end
         if (nogap && started) check("no_gap", 64'(fifo_if.out_valid), 64'd1);
         if (fifo_if.in_valid && fifo_if.in_ready) begin
            q.push_back(next_word);
            next_word = next_word + 1;
            sent++;
         end
         if (fifo_if.out_valid && fifo_if.out_ready) begin
            exp_w = (q.size() > 0) ? q.pop_front() : ~fifo_if.out_data;
            check("order", 64'(fifo_if.out_data), 64'(exp_w));
            if (!started) first_cyc = cyc;
            started = 1'b1;
            got++;
         end
         stalled = fifo_if.out_valid && !fifo_if.out_ready;
         held    = fifo_if.out_data;
         tick();
         cyc++;
      end
      fifo_if.in_valid  = 1'b0;
      fifo_if.out_ready = 1'b0;
      if (got != target) check("drain_budget", 64'(got), 64'(target));
   endtask

   initial begin
      RST               = 1'b1;
      fifo_if.in_valid  = 1'b1;
      fifo_if.in_data   = 32'h0;
      fifo_if.out_ready = 1'b0;

      // Reset held three cycles with a pending write
      repeat (3) begin
         tick();
         check("rst_in_ready", 64'(fifo_if.in_ready), 64'd0);
         check("rst_out_valid", 64'(fifo_if.out_valid), 64'd0);
         check("rst_count", 64'(fifo_if.count), 64'd0);
         check("rst_web", 64'(sram_WEB), 64'd0);
         check("rst_reb", 64'(sram_REB), 64'd0);
      end
      check("rst_out_data", 64'(fifo_if.out_data), 64'd0);
      RST              = 1'b0;
      fifo_if.in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(fifo_if.in_ready), 64'd1);
      check("bweb_ones", 64'(sram_BWEB), 64'hFFFF_FFFF);
      tick();

      // Single word through an empty FIFO
      fifo_if.in_valid  = 1'b1;
      fifo_if.in_data   = 32'hDEAD_BEEF;
      fifo_if.out_ready = 1'b1;
      #1;
      check("single_web", 64'(sram_WEB), 64'd1);
      check("single_aa", 64'(sram_AA), 64'd0);
      check("single_d", 64'(sram_D), 64'hDEAD_BEEF);
      tick();
      fifo_if.in_valid = 1'b0;
      #1;
      check("single_reb", 64'(sram_REB), 64'd1);
      check("single_ab", 64'(sram_AB), 64'd0);
      check("single_count", 64'(fifo_if.count), 64'd1);
      check("single_nv_e0", 64'(fifo_if.out_valid), 64'd0);
      tick();
      check("single_nv_e1", 64'(fifo_if.out_valid), 64'd0);
      check("single_reb_off", 64'(sram_REB), 64'd0);
      tick();
      check("single_valid", 64'(fifo_if.out_valid), 64'd1);
      check("single_data", 64'(fifo_if.out_data), 64'hDEAD_BEEF);
      tick();
      check("single_count0", 64'(fifo_if.count), 64'd0);
      check("single_empty", 64'(fifo_if.out_valid), 64'd0);
      fifo_if.out_ready = 1'b0;

      // Fill with consumer stalled: 256 in SRAM + 2 in the buffer
      acc       = 0;
      next_word = 32'h0;
      for (int i = 0; i < 270; i++) begin
         fifo_if.in_valid = 1'b1;
         fifo_if.in_data  = next_word;
         #1;
         if (fifo_if.in_ready) begin
            q.push_back(next_word);
            next_word = next_word + 1;
            acc++;
         end
         tick();
      end
      fifo_if.in_valid = 1'b0;
      #1;
      check("fill_accepts", 64'(acc), 64'd258);
      check("fill_count", 64'(fifo_if.count), 64'd258);
      check("fill_in_ready", 64'(fifo_if.in_ready), 64'd0);
      check("fill_head", 64'(fifo_if.out_data), 64'd0);
      run_traffic(0, 0, 100, 1'b1, first_out);
      #1;
      check("fill_drain_count", 64'(fifo_if.count), 64'd0);

      // Full-rate streaming from empty
      next_word = 32'h1000_0000;
      run_traffic(1000, 100, 100, 1'b1, first_out);
      check("stream_latency", 64'(first_out), 64'd3);
      check("stream_count", 64'(fifo_if.count), 64'd0);

      // Random valid/ready, pointers wrap several times
      next_word = 32'h2000_0000;
      run_traffic(2000, 50, 50, 1'b0, first_out);
      check("random_count", 64'(fifo_if.count), 64'd0);

      // Reset with 100 words held
      acc = 0;
      for (int i = 0; i < 200 && acc < 100; i++) begin
         fifo_if.in_valid = 1'b1;
         fifo_if.in_data  = next_word;
         #1;
         if (fifo_if.in_ready) begin
            next_word = next_word + 1;
            acc++;
         end
         tick();
      end
      fifo_if.in_valid = 1'b0;
      #1;
      check("mid_count100", 64'(fifo_if.count), 64'd100);
      RST = 1'b1;
      tick();
      check("mid_rst_valid", 64'(fifo_if.out_valid), 64'd0);
      check("mid_rst_count", 64'(fifo_if.count), 64'd0);
      RST = 1'b0;
      #1;
      check("mid_rst_aa", 64'(sram_AA), 64'd0);
      check("mid_rst_ab", 64'(sram_AB), 64'd0);
      q.delete();
      next_word = 32'h3000_0000;
      run_traffic(64, 100, 100, 1'b1, first_out);
      check("mid_rst_latency", 64'(first_out), 64'd3);
      check("mid_rst_final", 64'(fifo_if.count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
